// File: rtl/ddr_if_pkg.sv
// Shared definitions for the DDR interface link controller: FSM state encoding,
// lane geometry and the training-word lane mapping.
package ddr_if_pkg;

  localparam int NLANES = 5;
  localparam int WORD_W = 14;

  typedef logic [WORD_W-1:0] lane_word_t;
  typedef lane_word_t [NLANES-1:0] lane_bus_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DCM_RST    = 3'd1,
    WAIT_LOCK  = 3'd2,
    SERDES_RST = 3'd3,
    TRAIN      = 3'd4,
    RUN        = 3'd5,
    FAULT      = 3'd6
  } link_state_t;

  // Even lanes carry the training word, odd lanes its inverse.
  function automatic lane_bus_t train_bus(input lane_word_t pat);
    lane_bus_t bus;
    for (int i = 0; i < NLANES; i++) begin
      bus[i] = ((i % 2) != 0) ? ~pat : pat;
    end
    return bus;
  endfunction

endpackage

// File: rtl/ddr_if_link_ctrl_sync_2ff.sv
// Two-flop synchronizer used to bring the asynchronous DCM lock into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr_if_link_ctrl.sv
// DDR interface link bring-up: DCM reset, lock wait, OSERDES reset, training, run.
// Optional lock monitoring in RUN (relock counting) is enabled by DDR_IF_LOCK_MONITOR_EN.
module ddr_if_link_ctrl
  import ddr_if_pkg::*;
#(
  parameter int         DCM_RST_CYC    = 16,
  parameter int         LOCK_TIMEOUT   = 4096,
  parameter int         SERDES_RST_CYC = 8,
  parameter int         TRAIN_CYC      = 256,
  parameter lane_word_t TRAIN_PAT      = 14'h2A55
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           dcm_lock,
  input  logic [NLANES-1:0][WORD_W-1:0]  data_in,
  output logic                           dcm_reset,
  output logic                           serdes_rst,
  output logic [NLANES-1:0][WORD_W-1:0]  data_out,
  output logic                           link_up,
  output logic                           fault,
  output logic [7:0]                     relock_cnt,
  output logic [2:0]                     state
);

  localparam int MAX_AB  = (DCM_RST_CYC > LOCK_TIMEOUT) ? DCM_RST_CYC : LOCK_TIMEOUT;
  localparam int MAX_CD  = (SERDES_RST_CYC > TRAIN_CYC) ? SERDES_RST_CYC : TRAIN_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC);

  link_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dcm_lock),
    .q       (lock_s)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = DCM_RST;
        DCM_RST:    if (cnt_q == CNT_W'(DCM_RST_CYC - 1)) state_d = WAIT_LOCK;
        // Lock wins over a timeout landing in the same cycle.
        WAIT_LOCK: begin
          if (lock_s)                                  state_d = SERDES_RST;
          else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))  state_d = FAULT;
        end
        SERDES_RST: begin
          if (!lock_s)                                   state_d = DCM_RST;
          else if (cnt_q == CNT_W'(SERDES_RST_CYC - 1))  state_d = TRAIN;
        end
        TRAIN: begin
          if (!lock_s)                              state_d = DCM_RST;
          else if (cnt_q == CNT_W'(TRAIN_CYC - 1))  state_d = RUN;
        end
        RUN: begin
`ifdef DDR_IF_LOCK_MONITOR_EN
          if (!lock_s) state_d = DCM_RST;
`endif
        end
        FAULT:      state_d = FAULT;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Phase counter restarts on every state change; it free-runs in idle states.
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dcm_reset  <= 1'b1;
      serdes_rst <= 1'b1;
      link_up    <= 1'b0;
      fault      <= 1'b0;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcm_reset  <= (state_d == IDLE) || (state_d == DCM_RST) || (state_d == FAULT);
      serdes_rst <= (state_d == IDLE) || (state_d == SERDES_RST);
      link_up    <= (state_d == RUN);
      fault      <= (state_d == FAULT);
      case (state_d)
        TRAIN:   data_out <= train_bus(TRAIN_PAT);
        RUN:     data_out <= data_in;
        default: data_out <= '0;
      endcase
    end
  end

`ifdef DDR_IF_LOCK_MONITOR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      relock_cnt <= '0;
    end else if (state_q == RUN && state_d == DCM_RST && relock_cnt != 8'hFF) begin
      relock_cnt <= relock_cnt + 8'd1;
    end
  end
`else
  assign relock_cnt = '0;
`endif

  assign state = state_q;

endmodule
